// File: rtl/interrupt_ctrl.sv
// Interrupt controller: rising-edge capture into pending bits, masked lowest-index
// arbitration, and a request/service handshake with the CPU. Optional IRQ_OVERRUN_CNT_EN.
module interrupt_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic [NUM_SRC-1:0] sw_clear,
    input  logic               interrupt_ack,
    input  logic               eoi,
    output logic               interrupt,
    output logic [VEC_W-1:0]   vector,
    output logic [NUM_SRC-1:0] pending,
`ifdef IRQ_OVERRUN_CNT_EN
    output logic               in_service,
    output logic [8*NUM_SRC-1:0] overrun_cnt
`else
    output logic               in_service
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   src_q;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic                 interrupt_q, interrupt_d;
    logic [VEC_W-1:0]     vector_q, vector_d;
    logic                 in_service_q, in_service_d;

    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   clr;
    logic [VEC_W-1:0]     winner;
    logic                 ack_clr;

    assign rise = irq_src & ~src_q;
    assign req  = pending_q & irq_mask;
    assign clr  = sw_clear | (ack_clr ? (NUM_SRC'(1) << vector_q) : '0);

    // Set has priority over clear so an event arriving during a clear is never lost.
    assign pending_d = (pending_q & ~clr) | rise;

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        interrupt_d  = interrupt_q;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        ack_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    vector_d    = winner;
                    interrupt_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Request is held regardless of mask/sw_clear until the CPU acks it.
                if (interrupt_ack) begin
                    interrupt_d  = 1'b0;
                    in_service_d = 1'b1;
                    ack_clr      = 1'b1;
                    state_d      = SVC;
                end
            end
            SVC: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            pending_q    <= '0;
            interrupt_q  <= 1'b0;
            vector_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= irq_src;
            pending_q    <= pending_d;
            interrupt_q  <= interrupt_d;
            vector_q     <= vector_d;
            in_service_q <= in_service_d;
        end
    end

    assign interrupt  = interrupt_q;
    assign vector     = vector_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

`ifdef IRQ_OVERRUN_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] cnt_q [NUM_SRC];

    // An overrun is a new edge landing on a bit that is still pending and survives this cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reset) begin
                cnt_q[i] <= 8'd0;
            end else if (rise[i] && pending_q[i] && !clr[i]) begin
                cnt_q[i] <= sat_inc8(cnt_q[i]);
            end
        end
    end

    always_comb begin
        overrun_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            overrun_cnt[8*i +: 8] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed self-checking bench for interrupt_ctrl (overrun checks under IRQ_OVERRUN_CNT_EN).
module tb_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic [3:0] irq_mask;
    logic [3:0] sw_clear;
    logic       interrupt_ack;
    logic       eoi;
    logic       interrupt;
    logic [1:0] vector;
    logic [3:0] pending;
    logic       in_service;
`ifdef IRQ_OVERRUN_CNT_EN
    logic [31:0] overrun_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_ctrl #(.NUM_SRC(4), .VEC_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .irq_src       (irq_src),
        .irq_mask      (irq_mask),
        .sw_clear      (sw_clear),
        .interrupt_ack (interrupt_ack),
        .eoi           (eoi),
        .interrupt     (interrupt),
        .vector        (vector),
        .pending       (pending),
`ifdef IRQ_OVERRUN_CNT_EN
        .in_service    (in_service),
        .overrun_cnt   (overrun_cnt)
`else
        .in_service    (in_service)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack();
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_src = 4'h0; irq_mask = 4'hF; sw_clear = 4'h0;
        interrupt_ack = 1'b0; eoi = 1'b0;
        tick(3);
        check("rst_int", {31'd0, interrupt}, 32'd0);
        check("rst_vec", {30'd0, vector}, 32'd0);
        check("rst_pend", {28'd0, pending}, 32'd0);
        check("rst_svc", {31'd0, in_service}, 32'd0);

        // source high at reset release
        reset = 1'b0; irq_src = 4'b0100;
        tick(1);
        check("t1_pend", {28'd0, pending}, 32'h4);
        check("t1_int_lat", {31'd0, interrupt}, 32'd0);
        tick(1);
        check("t1_int", {31'd0, interrupt}, 32'd1);
        check("t1_vec", {30'd0, vector}, 32'd2);
        do_ack();
        check("t1_ack_int", {31'd0, interrupt}, 32'd0);
        check("t1_ack_svc", {31'd0, in_service}, 32'd1);
        check("t1_ack_pend", {28'd0, pending}, 32'h0);
        do_eoi();
        check("t1_eoi_svc", {31'd0, in_service}, 32'd0);
        irq_src = 4'h0;
        tick(2);

        // two-cycle pulse on src0
        irq_src = 4'b0001;
        tick(1);
        check("t2_pend", {28'd0, pending}, 32'h1);
        check("t2_int_lat", {31'd0, interrupt}, 32'd0);
        tick(1);
        irq_src = 4'h0;
        check("t2_int", {31'd0, interrupt}, 32'd1);
        check("t2_vec", {30'd0, vector}, 32'd0);
        tick(3);
        check("t2_int_hold", {31'd0, interrupt}, 32'd1);
        do_ack();
        check("t2_ack_int", {31'd0, interrupt}, 32'd0);
        check("t2_ack_pend", {28'd0, pending}, 32'h0);
        check("t2_ack_svc", {31'd0, in_service}, 32'd1);
        tick(4);
        do_eoi();
        check("t2_eoi_svc", {31'd0, in_service}, 32'd0);
        tick(1);
        check("t2_one_event", {31'd0, interrupt}, 32'd0);

        // simultaneous src1 and src3
        irq_src = 4'b1010;
        tick(1);
        irq_src = 4'h0;
        check("t3_pend", {28'd0, pending}, 32'hA);
        tick(1);
        check("t3_int1", {31'd0, interrupt}, 32'd1);
        check("t3_vec1", {30'd0, vector}, 32'd1);
        do_ack();
        check("t3_pend_ack", {28'd0, pending}, 32'h8);
        do_eoi();
        check("t3_eoi_int", {31'd0, interrupt}, 32'd0);
        tick(1);
        check("t3_int3", {31'd0, interrupt}, 32'd1);
        check("t3_vec3", {30'd0, vector}, 32'd3);
        do_ack();
        do_eoi();
        check("t3_pend_end", {28'd0, pending}, 32'h0);

        // masking and set-beats-clear
        irq_mask = 4'b1110;
        irq_src = 4'b0001;
        tick(1);
        irq_src = 4'h0;
        check("t4_pend_masked", {28'd0, pending}, 32'h1);
        tick(2);
        check("t4_int_masked", {31'd0, interrupt}, 32'd0);
        irq_mask = 4'hF;
        tick(1);
        check("t4_int_unmask", {31'd0, interrupt}, 32'd1);
        check("t4_vec", {30'd0, vector}, 32'd0);
        irq_src = 4'b0001; sw_clear = 4'b0001;
        tick(1);
        check("t4_set_wins", {28'd0, pending}, 32'h1);
        irq_src = 4'h0;
        tick(1);
        check("t4_sw_clr", {28'd0, pending}, 32'h0);
        sw_clear = 4'h0;
        check("t4_req_held", {31'd0, interrupt}, 32'd1);
        do_ack();
        check("t4_ack_int", {31'd0, interrupt}, 32'd0);
        check("t4_ack_svc", {31'd0, in_service}, 32'd1);
        do_eoi();

        // reset during SVC
        irq_src = 4'b1010;
        tick(1);
        irq_src = 4'h0;
        tick(1);
        do_ack();
        check("t5_in_svc", {31'd0, in_service}, 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5s_int", {31'd0, interrupt}, 32'd0);
        check("t5s_svc", {31'd0, in_service}, 32'd0);
        check("t5s_pend", {28'd0, pending}, 32'h0);
        tick(1);
        // reset during REQ
        irq_src = 4'b0010;
        tick(1);
        irq_src = 4'h0;
        tick(1);
        check("t5_in_req", {31'd0, interrupt}, 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5r_int", {31'd0, interrupt}, 32'd0);
        check("t5r_vec", {30'd0, vector}, 32'd0);
        check("t5r_pend", {28'd0, pending}, 32'h0);
        tick(1);
        // stray strobes in IDLE
        eoi = 1'b1; interrupt_ack = 1'b1;
        tick(1);
        eoi = 1'b0; interrupt_ack = 1'b0;
        tick(1);
        check("t5_stray_int", {31'd0, interrupt}, 32'd0);
        check("t5_stray_svc", {31'd0, in_service}, 32'd0);
        check("t5_stray_pend", {28'd0, pending}, 32'h0);

`ifdef IRQ_OVERRUN_CNT_EN
        // repeated pulses on src2 without ack: first sets pending, the rest overrun
        for (int k = 0; k < 10; k++) begin
            irq_src = 4'b0100;
            tick(1);
            irq_src = 4'h0;
            tick(1);
        end
        check("t6_cnt_mid", {24'd0, overrun_cnt[23:16]}, 32'd9);
        for (int k = 0; k < 290; k++) begin
            irq_src = 4'b0100;
            tick(1);
            irq_src = 4'h0;
            tick(1);
        end
        check("t6_cnt_sat", {24'd0, overrun_cnt[23:16]}, 32'd255);
        check("t6_cnt_other", {8'd0, overrun_cnt[31:24], overrun_cnt[15:0]}, 32'd0);
        check("t6_pend", {28'd0, pending}, 32'h4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_cnt_rst", overrun_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
